// File: rtl/dap_cmd_dispatcher_pkg.sv
// Shared state encoding and constants for the DAP command dispatcher and its ID matcher.
package dap_cmd_dispatcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_ERR_WR = 3'd3,
        ST_RESP   = 3'd4
    } disp_state_t;

    localparam int          DEF_CMD_NUM   = 8;
    localparam logic [63:0] DEF_CMD_IDS   = {8'h07, 8'h06, 8'h05, 8'h04,
                                             8'h03, 8'h02, 8'h01, 8'h00};
    localparam logic [7:0]  ERR_RESP_BYTE = 8'hFF;

    // Bits needed for a counter that runs from 0 to limit-1.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/dap_cmd_id_match.sv
// Compares a peeked command byte against every engine ID and picks the lowest-index match.
module dap_cmd_id_match
    import dap_cmd_dispatcher_pkg::*;
#(
    parameter int                   CMD_NUM = DEF_CMD_NUM,
    parameter logic [CMD_NUM*8-1:0] CMD_IDS = DEF_CMD_IDS
) (
    input  logic [7:0]         cmd_id,
    output logic               hit,
    output logic [CMD_NUM-1:0] sel
);

    localparam logic [CMD_NUM-1:0] LSB_ONE = CMD_NUM'(1'b1);

    logic [CMD_NUM-1:0] match_s;

    // Per-engine ID compare.
    always_comb begin
        for (int i = 0; i < CMD_NUM; i++) begin
            match_s[i] = (cmd_id == CMD_IDS[i*8 +: 8]);
        end
    end

    // Isolating the lowest set bit resolves duplicate IDs to the lowest engine index.
    assign sel = match_s & (~match_s + LSB_ONE);
    assign hit = |match_s;

endmodule

// File: rtl/dap_cmd_dispatcher.sv
// Dispatches request packets to DAP command engines, muxes their stream/RAM ports,
// and reports the response length (or a 1-byte 0xFF error response) to the USB side.
module dap_cmd_dispatcher
    import dap_cmd_dispatcher_pkg::*;
#(
    parameter int                   CMD_NUM = DEF_CMD_NUM,
    parameter logic [CMD_NUM*8-1:0] CMD_IDS = DEF_CMD_IDS,
    parameter int                   ADDR_W  = 10,
    parameter int                   TIMEOUT = 6_000_000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      dap_in_tvalid,
    input  logic [7:0]                dap_in_tdata,
    input  logic                      dap_in_tlast,
    output logic                      dap_in_tready,
    output logic [CMD_NUM-1:0]        cmd_start,
    input  logic [CMD_NUM-1:0]        cmd_done,
    input  logic [CMD_NUM-1:0]        cmd_tready,
    input  logic [CMD_NUM-1:0]        cmd_ram_we,
    input  logic [CMD_NUM*ADDR_W-1:0] cmd_ram_addr,
    input  logic [CMD_NUM*8-1:0]      cmd_ram_data,
    input  logic [CMD_NUM*ADDR_W-1:0] cmd_packet_len,
    output logic                      ram_write_en,
    output logic [ADDR_W-1:0]         ram_write_addr,
    output logic [7:0]                ram_write_data,
    output logic                      resp_valid,
    output logic [ADDR_W-1:0]         resp_len,
    input  logic                      resp_ready,
    output logic                      busy,
    output logic                      err_unknown,
    output logic                      err_timeout
);

    localparam int                 CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);
    localparam logic [ADDR_W-1:0]  ERR_LEN  = ADDR_W'(1'b1);

    disp_state_t         state_r, state_nxt_s;
    logic [CMD_NUM-1:0]  sel_r, sel_nxt_s;
    logic [CMD_NUM-1:0]  cmd_start_r, cmd_start_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                tlast_seen_r, tlast_seen_nxt_s;
    logic [ADDR_W-1:0]   resp_len_r, resp_len_nxt_s;
    logic                resp_valid_r, resp_valid_nxt_s;
    logic                busy_r;
    logic                err_unknown_r, err_unknown_nxt_s;
    logic                err_timeout_r, err_timeout_nxt_s;

    logic                id_hit_s;
    logic [CMD_NUM-1:0]  id_sel_s;
    logic                mux_tready_s;
    logic                mux_we_s;
    logic [ADDR_W-1:0]   mux_addr_s;
    logic [7:0]          mux_data_s;
    logic [ADDR_W-1:0]   mux_len_s;
    logic                done_s;
    logic                beat_s;
    logic                tlast_now_s;

    dap_cmd_id_match #(
        .CMD_NUM (CMD_NUM),
        .CMD_IDS (CMD_IDS)
    ) u_id_match (
        .cmd_id (dap_in_tdata),
        .hit    (id_hit_s),
        .sel    (id_sel_s)
    );

    // One-hot AND-OR muxes over the engine ports, keyed by the latched selection.
    always_comb begin
        mux_tready_s = 1'b0;
        mux_we_s     = 1'b0;
        mux_addr_s   = {ADDR_W{1'b0}};
        mux_data_s   = 8'h00;
        mux_len_s    = {ADDR_W{1'b0}};
        for (int i = 0; i < CMD_NUM; i++) begin
            mux_tready_s = mux_tready_s | (cmd_tready[i] & sel_r[i]);
            mux_we_s     = mux_we_s | (cmd_ram_we[i] & sel_r[i]);
            mux_addr_s   = mux_addr_s | (cmd_ram_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{sel_r[i]}});
            mux_data_s   = mux_data_s | (cmd_ram_data[i*8 +: 8] & {8{sel_r[i]}});
            mux_len_s    = mux_len_s | (cmd_packet_len[i*ADDR_W +: ADDR_W] & {ADDR_W{sel_r[i]}});
        end
    end

    assign done_s      = |(cmd_done & sel_r);
    assign beat_s      = dap_in_tvalid & dap_in_tready;
    assign tlast_now_s = tlast_seen_r | (beat_s & dap_in_tlast);

    // Stream ready and shared RAM port, both driven straight from the current state.
    always_comb begin
        dap_in_tready  = 1'b0;
        ram_write_en   = 1'b0;
        ram_write_addr = {ADDR_W{1'b0}};
        ram_write_data = 8'h00;
        case (state_r)
            ST_RUN: begin
                dap_in_tready  = mux_tready_s;
                ram_write_en   = mux_we_s;
                ram_write_addr = mux_addr_s;
                ram_write_data = mux_data_s;
            end
            ST_DRAIN: begin
                dap_in_tready = 1'b1;
            end
            ST_ERR_WR: begin
                ram_write_en   = 1'b1;
                ram_write_data = ERR_RESP_BYTE;
            end
            default: begin
                dap_in_tready = 1'b0;
            end
        endcase
    end

    // Next-state logic; done takes priority over the timeout in the same cycle.
    always_comb begin
        state_nxt_s       = state_r;
        sel_nxt_s         = sel_r;
        cmd_start_nxt_s   = cmd_start_r;
        cnt_nxt_s         = cnt_r;
        tlast_seen_nxt_s  = tlast_seen_r;
        resp_len_nxt_s    = resp_len_r;
        resp_valid_nxt_s  = resp_valid_r;
        err_unknown_nxt_s = 1'b0;
        err_timeout_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dap_in_tvalid) begin
                    tlast_seen_nxt_s = 1'b0;
                    cnt_nxt_s        = {CNT_W{1'b0}};
                    if (id_hit_s) begin
                        sel_nxt_s       = id_sel_s;
                        cmd_start_nxt_s = id_sel_s;
                        state_nxt_s     = ST_RUN;
                    end else begin
                        err_unknown_nxt_s = 1'b1;
                        state_nxt_s       = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_nxt_s        = cnt_r + CNT_ONE;
                tlast_seen_nxt_s = tlast_now_s;
                if (done_s) begin
                    cmd_start_nxt_s  = {CMD_NUM{1'b0}};
                    sel_nxt_s        = {CMD_NUM{1'b0}};
                    resp_len_nxt_s   = mux_len_s;
                    resp_valid_nxt_s = 1'b1;
                    state_nxt_s      = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    cmd_start_nxt_s   = {CMD_NUM{1'b0}};
                    sel_nxt_s         = {CMD_NUM{1'b0}};
                    err_timeout_nxt_s = 1'b1;
                    state_nxt_s       = tlast_now_s ? ST_ERR_WR : ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (dap_in_tvalid && dap_in_tlast) begin
                    state_nxt_s = ST_ERR_WR;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_ERR_WR: begin
                resp_len_nxt_s   = ERR_LEN;
                resp_valid_nxt_s = 1'b1;
                state_nxt_s      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_nxt_s = 1'b0;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                cmd_start_nxt_s  = {CMD_NUM{1'b0}};
                sel_nxt_s        = {CMD_NUM{1'b0}};
                resp_valid_nxt_s = 1'b0;
                state_nxt_s      = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            sel_r         <= {CMD_NUM{1'b0}};
            cmd_start_r   <= {CMD_NUM{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            tlast_seen_r  <= 1'b0;
            resp_len_r    <= {ADDR_W{1'b0}};
            resp_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
            err_unknown_r <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            sel_r         <= sel_nxt_s;
            cmd_start_r   <= cmd_start_nxt_s;
            cnt_r         <= cnt_nxt_s;
            tlast_seen_r  <= tlast_seen_nxt_s;
            resp_len_r    <= resp_len_nxt_s;
            resp_valid_r  <= resp_valid_nxt_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            err_unknown_r <= err_unknown_nxt_s;
            err_timeout_r <= err_timeout_nxt_s;
        end
    end

    assign cmd_start   = cmd_start_r;
    assign resp_valid  = resp_valid_r;
    assign resp_len    = resp_len_r;
    assign busy        = busy_r;
    assign err_unknown = err_unknown_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_dap_cmd_dispatcher.sv
// Directed bench for dap_cmd_dispatcher: a request source, hand-driven engines, and a
// write/length scoreboard that is checked every cycle.
module tb_dap_cmd_dispatcher;
    import dap_cmd_dispatcher_pkg::*;

    localparam int N   = 8;
    localparam int AW  = 10;
    localparam int TMO = 100;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              dap_in_tvalid;
    logic [7:0]        dap_in_tdata;
    logic              dap_in_tlast;
    logic              dap_in_tready;
    logic [N-1:0]      cmd_start;
    logic [N-1:0]      cmd_done;
    logic [N-1:0]      cmd_tready;
    logic [N-1:0]      cmd_ram_we;
    logic [N*AW-1:0]   cmd_ram_addr;
    logic [N*8-1:0]    cmd_ram_data;
    logic [N*AW-1:0]   cmd_packet_len;
    logic              ram_write_en;
    logic [AW-1:0]     ram_write_addr;
    logic [7:0]        ram_write_data;
    logic              resp_valid;
    logic [AW-1:0]     resp_len;
    logic              resp_ready;
    logic              busy;
    logic              err_unknown;
    logic              err_timeout;

    int checks = 0;
    int failures = 0;
    int consumed = 0;
    int unk_cnt = 0;
    int tmo_cnt = 0;
    int start_hi_cnt = 0;
    int base;
    beat_t         src_q[$];
    wr_t           exp_wr_q[$];
    logic [AW-1:0] exp_len = '0;
    logic [7:0]    ram_mem [0:(1<<AW)-1];

    dap_cmd_dispatcher #(
        .CMD_NUM (N),
        .ADDR_W  (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .dap_in_tvalid  (dap_in_tvalid),
        .dap_in_tdata   (dap_in_tdata),
        .dap_in_tlast   (dap_in_tlast),
        .dap_in_tready  (dap_in_tready),
        .cmd_start      (cmd_start),
        .cmd_done       (cmd_done),
        .cmd_tready     (cmd_tready),
        .cmd_ram_we     (cmd_ram_we),
        .cmd_ram_addr   (cmd_ram_addr),
        .cmd_ram_data   (cmd_ram_data),
        .cmd_packet_len (cmd_packet_len),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .resp_valid     (resp_valid),
        .resp_len       (resp_len),
        .resp_ready     (resp_ready),
        .busy           (busy),
        .err_unknown    (err_unknown),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input int n, input logic [39:0] bytes);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = bytes[39-8*i -: 8];
            b.last = (i == n - 1);
            src_q.push_back(b);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr_q.push_back(w);
    endtask

    task automatic wait_start(input int e);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_start != '0) break;
        end
        chk($sformatf("start_engine%0d", e), 32'(cmd_start), 32'h1 << e);
    endtask

    task automatic wait_resp(input string name);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        chk(name, 32'(resp_valid), 32'h1);
    endtask

    task automatic wait_consumed(input int target);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (consumed >= target) break;
        end
        chk("consumed_reach", 32'(consumed >= target), 32'h1);
    endtask

    task automatic accept();
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // Request source: presents the queue head and pops it on each accepted beat.
    initial begin : src_proc
        logic  hs;
        beat_t b;
        dap_in_tvalid = 1'b0;
        dap_in_tdata  = 8'h00;
        dap_in_tlast  = 1'b0;
        forever begin
            @(negedge clk);
            hs = dap_in_tvalid && dap_in_tready;
            if (hs) consumed++;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) b = src_q.pop_front();
            if (src_q.size() > 0) begin
                dap_in_tvalid = 1'b1;
                dap_in_tdata  = src_q[0].data;
                dap_in_tlast  = src_q[0].last;
            end else begin
                dap_in_tvalid = 1'b0;
                dap_in_tdata  = 8'h00;
                dap_in_tlast  = 1'b0;
            end
        end
    end

    // Per-cycle compare against the scoreboard and the response-length model.
    initial begin : cmp_proc
        wr_t w;
        forever begin
            @(negedge clk);
            if (ram_write_en) begin
                ram_mem[ram_write_addr] = ram_write_data;
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_ram_write", 32'(ram_write_en), 32'h0);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("ram_write_addr", 32'(ram_write_addr), 32'(w.addr));
                    chk("ram_write_data", 32'(ram_write_data), 32'(w.data));
                end
            end
            if (resp_valid) begin
                chk("resp_len_model", 32'(resp_len), 32'(exp_len));
                chk("resp_blocks_tready", 32'(dap_in_tready), 32'h0);
            end
            if (cmd_start != '0) begin
                chk("start_onehot", 32'($onehot(cmd_start)), 32'h1);
                start_hi_cnt++;
            end
            if (err_unknown) unk_cnt++;
            if (err_timeout) tmo_cnt++;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog run did not complete");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : main
        resetn     = 1'b0;
        resp_ready = 1'b0;
        cmd_done   = '0;
        cmd_tready = '0;
        cmd_ram_we = '0;
        for (int i = 0; i < N; i++) begin
            cmd_ram_addr[i*AW +: AW]   = AW'(i * 37 + 5);
            cmd_ram_data[i*8 +: 8]     = 8'(i * 17 + 3);
            cmd_packet_len[i*AW +: AW] = AW'(i + 100);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_start", 32'(cmd_start), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_len", 32'(resp_len), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tready", 32'(dap_in_tready), 32'h0);
        chk("rst_ram_we", 32'(ram_write_en), 32'h0);
        chk("rst_err_unknown", 32'(err_unknown), 32'h0);
        chk("rst_err_timeout", 32'(err_timeout), 32'h0);
        tick();
        resetn = 1'b1;

        // Normal dispatch to engine 2.
        push_pkt(5, 40'h02_11_22_33_44);
        wait_start(2);
        chk("cmd_byte_not_consumed", 32'(consumed), 32'h0);
        chk("busy_in_run", 32'(busy), 32'h1);
        tick();
        cmd_tready[2] = 1'b1;
        wait_consumed(5);
        tick();
        cmd_tready[2] = 1'b0;
        // Engine 5 is not selected: its writes and done must be ignored.
        cmd_ram_we[5] = 1'b1;
        cmd_done[5]   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nonsel_start_held", 32'(cmd_start), 32'h04);
            chk("nonsel_no_resp", 32'(resp_valid), 32'h0);
            chk("nonsel_no_write", 32'(ram_write_en), 32'h0);
        end
        tick();
        cmd_ram_we[5] = 1'b0;
        cmd_done[5]   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd_ram_we[2]          = 1'b1;
            cmd_ram_addr[2*AW +: AW] = AW'(k);
            cmd_ram_data[2*8 +: 8] = 8'hA0 + 8'(k);
            push_wr(AW'(k), 8'hA0 + 8'(k));
            tick();
        end
        cmd_ram_we[2] = 1'b0;
        tick();
        cmd_packet_len[2*AW +: AW] = 10'd3;
        cmd_done[2] = 1'b1;
        exp_len = 10'd3;
        @(negedge clk);
        chk("resp_not_before_done_edge", 32'(resp_valid), 32'h0);
        chk("start_held_until_done", 32'(cmd_start), 32'h04);
        tick();
        cmd_done[2] = 1'b0;
        @(negedge clk);
        chk("resp_valid_after_done", 32'(resp_valid), 32'h1);
        chk("resp_len_engine2", 32'(resp_len), 32'd3);
        chk("start_dropped_at_done", 32'(cmd_start), 32'h0);
        chk("ram_writes_engine2", 32'(exp_wr_q.size()), 32'h0);

        // Response stall with the next (unknown) packet already waiting.
        base = consumed;
        push_pkt(4, 40'hEE_01_02_03_00);
        push_wr(10'd0, 8'hFF);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("stall_tready_low", 32'(dap_in_tready), 32'h0);
            chk("stall_resp_valid", 32'(resp_valid), 32'h1);
            chk("stall_resp_len", 32'(resp_len), 32'd3);
        end
        chk("stall_no_consume", 32'(consumed - base), 32'h0);
        accept();
        exp_len = 10'd1;
        @(negedge clk);
        chk("resp_accepted", 32'(resp_valid), 32'h0);

        // Unknown command: drained, answered with 0xFF length 1.
        wait_resp("resp_unknown");
        chk("unknown_pulses", 32'(unk_cnt), 32'd1);
        chk("unknown_drained", 32'(consumed - base), 32'd4);
        chk("unknown_resp_len", 32'(resp_len), 32'd1);
        chk("unknown_ram0", 32'(ram_mem[0]), 32'hFF);
        chk("unknown_no_timeout", 32'(tmo_cnt), 32'd0);
        accept();

        // Timeout before tlast: start drops after TMO run cycles, rest of packet drained.
        tick();
        start_hi_cnt = 0;
        base = consumed;
        push_pkt(3, 40'h03_AA_BB_00_00);
        push_wr(10'd0, 8'hFF);
        wait_start(3);
        tick();
        cmd_tready[3] = 1'b1;
        tick();
        cmd_tready[3] = 1'b0;
        wait_resp("resp_timeout_drain");
        chk("timeout_start_cycles", 32'(start_hi_cnt), 32'(TMO));
        chk("timeout_pulses", 32'(tmo_cnt), 32'd1);
        chk("timeout_drained", 32'(consumed - base), 32'd3);
        chk("timeout_resp_len", 32'(resp_len), 32'd1);
        accept();

        // Timeout after the engine took tlast: no drain, next packet left intact.
        tick();
        start_hi_cnt = 0;
        base = consumed;
        push_pkt(2, 40'h04_CC_00_00_00);
        push_wr(10'd0, 8'hFF);
        wait_start(4);
        tick();
        cmd_tready[4] = 1'b1;
        wait_consumed(base + 2);
        tick();
        cmd_tready[4] = 1'b0;
        push_pkt(2, 40'h01_DD_00_00_00);
        wait_resp("resp_timeout_nodrain");
        chk("nodrain_start_cycles", 32'(start_hi_cnt), 32'(TMO));
        chk("nodrain_pulses", 32'(tmo_cnt), 32'd2);
        chk("nodrain_consumed", 32'(consumed - base), 32'd2);
        accept();
        wait_start(1);

        // Asynchronous reset in the middle of a run.
        tick();
        cmd_ram_we[1]            = 1'b1;
        cmd_ram_addr[1*AW +: AW] = 10'd3;
        cmd_ram_data[1*8 +: 8]   = 8'h77;
        push_wr(10'd3, 8'h77);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_cmd_start", 32'(cmd_start), 32'h0);
        chk("arst_ram_we", 32'(ram_write_en), 32'h0);
        chk("arst_resp_valid", 32'(resp_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        cmd_ram_we[1] = 1'b0;
        src_q.delete();
        tick();
        tick();
        resetn = 1'b1;

        // Dispatch after reset, max address/length, response accepted in its first cycle.
        base = consumed;
        push_pkt(2, 40'h07_5A_00_00_00);
        wait_start(7);
        tick();
        cmd_tready[7] = 1'b1;
        wait_consumed(base + 2);
        tick();
        cmd_tready[7]            = 1'b0;
        cmd_ram_we[7]            = 1'b1;
        cmd_ram_addr[7*AW +: AW] = 10'h3FF;
        cmd_ram_data[7*8 +: 8]   = 8'hC3;
        push_wr(10'h3FF, 8'hC3);
        tick();
        cmd_ram_we[7] = 1'b0;
        resp_ready    = 1'b1;
        cmd_packet_len[7*AW +: AW] = 10'h3FF;
        cmd_done[7] = 1'b1;
        exp_len = 10'h3FF;
        tick();
        cmd_done[7] = 1'b0;
        @(negedge clk);
        chk("max_resp_valid", 32'(resp_valid), 32'h1);
        chk("max_resp_len", 32'(resp_len), 32'h3FF);
        @(negedge clk);
        chk("same_cycle_accept", 32'(resp_valid), 32'h0);
        chk("idle_after_accept", 32'(busy), 32'h0);
        chk("ram_3ff", 32'(ram_mem[10'h3FF]), 32'hC3);
        tick();
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_wr_q.size()), 32'h0);
        chk("total_unknown", 32'(unk_cnt), 32'd1);
        chk("total_timeout", 32'(tmo_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
